// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core request/response and dual memory port bundle for dmem_arbiter
interface dmem_arbiter_if #(parameter int NUM_CORES = 4);
  logic [NUM_CORES-1:0] core_req, core_we, core_resp_valid, core_resp_err;
  logic [NUM_CORES*32-1:0] core_addr, core_wdata, core_rdata;
  logic mem_we_a, mem_we_b;
  logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
  modport slave (
    input core_req, core_we, core_addr, core_wdata, mem_rdata_a, mem_rdata_b,
    output core_resp_valid, core_resp_err, core_rdata,
    output mem_we_a, mem_addr_a, mem_wdata_a, mem_we_b, mem_addr_b, mem_wdata_b
  );
  modport master (
    output core_req, core_we, core_addr, core_wdata, mem_rdata_a, mem_rdata_b,
    input core_resp_valid, core_resp_err, core_rdata,
    input mem_we_a, mem_addr_a, mem_wdata_a, mem_we_b, mem_addr_b, mem_wdata_b
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of a dual-port data memory among NUM_CORES cores
module dmem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int CORE_W = 2,
  parameter int CNT_W = 16
) (
  input logic CLK,
  input logic RSTB,
  dmem_arbiter_if.slave bus,
  output logic [CNT_W-1:0] conflict_cnt
);
  logic [31:0] addr [NUM_CORES];
  logic [31:0] wdata [NUM_CORES];
  logic [NUM_CORES-1:0] busy, in_range, elig, cand, err_now, grant_a, grant_b;
  logic [CORE_W-1:0] rr_ptr, a_idx, b_idx, last_idx, rr_next, c;
  logic [CORE_W:0] s;
  logic a_hit, b_hit, skipped;
  // a core stays blocked during its response cycle, so busy is the response register itself
  assign busy = bus.core_resp_valid;
  assign elig = bus.core_req & ~busy & {NUM_CORES{RSTB}};
  assign cand = elig & in_range;
  assign err_now = elig & ~in_range;
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      addr[i] = bus.core_addr[32*i +: 32];
      wdata[i] = bus.core_wdata[32*i +: 32];
      in_range[i] = addr[i][31:9] == '0;
    end
  end
  always_comb begin
    a_hit = 1'b0;
    b_hit = 1'b0;
    skipped = 1'b0;
    a_idx = '0;
    b_idx = '0;
    grant_a = '0;
    grant_b = '0;
    s = '0;
    c = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      s = {1'b0, rr_ptr} + (CORE_W+1)'(k);
      s = s >= (CORE_W+1)'(NUM_CORES) ? s - (CORE_W+1)'(NUM_CORES) : s;
      c = s[CORE_W-1:0];
      if (cand[c]) begin
        if (!a_hit) begin
          a_hit = 1'b1;
          a_idx = c;
          grant_a[c] = 1'b1;
        end else if (!b_hit) begin
          if (addr[c][31:2] == addr[a_idx][31:2] && (bus.core_we[a_idx] || bus.core_we[c]))
            skipped = 1'b1;
          else begin
            b_hit = 1'b1;
            b_idx = c;
            grant_b[c] = 1'b1;
          end
        end
      end
    end
  end
  assign last_idx = b_hit ? b_idx : a_idx;
  assign rr_next = last_idx == CORE_W'(NUM_CORES-1) ? '0 : last_idx + 1'b1;
  always_comb begin
    bus.mem_we_a = a_hit & bus.core_we[a_idx];
    bus.mem_addr_a = a_hit ? addr[a_idx] : '0;
    bus.mem_wdata_a = a_hit ? wdata[a_idx] : '0;
    bus.mem_we_b = b_hit & bus.core_we[b_idx];
    bus.mem_addr_b = b_hit ? addr[b_idx] : '0;
    bus.mem_wdata_b = b_hit ? wdata[b_idx] : '0;
  end
  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      bus.core_resp_valid <= '0;
      bus.core_resp_err <= '0;
      bus.core_rdata <= '0;
      conflict_cnt <= '0;
      rr_ptr <= '0;
    end else begin
      bus.core_resp_valid <= grant_a | grant_b | err_now;
      bus.core_resp_err <= err_now;
      for (int i = 0; i < NUM_CORES; i++)
        bus.core_rdata[32*i +: 32] <= err_now[i] ? '0 :
                                      grant_a[i] ? bus.mem_rdata_a :
                                      grant_b[i] ? bus.mem_rdata_b : bus.core_rdata[32*i +: 32];
      rr_ptr <= a_hit ? rr_next : rr_ptr;
      conflict_cnt <= (skipped && conflict_cnt != '1) ? conflict_cnt + 1'b1 : conflict_cnt;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a queue-based reference model
module tb_dmem_arbiter;
  logic CLK = 1'b0;
  logic RSTB = 1'b0;
  logic [15:0] conflict_cnt;
  logic [3:0] t_req = '0, t_we = '0;
  logic [31:0] t_addr [4] = '{default: '0};
  logic [31:0] t_wd [4] = '{default: '0};
  logic [31:0] mem_arr [128] = '{default: '0};
  logic [31:0] ref_mem [128] = '{default: '0};
  bit [3:0] m_busy = '0;
  int m_rr = 0, m_cnt = 0;
  int checks = 0, passed = 0, fails = 0;
  logic [127:0] exp_rdata = '0, obs_pa, obs_pb;
  logic [3:0] exp_valid = '0;

  dmem_arbiter_if #(.NUM_CORES(4)) bus ();
  dmem_arbiter #(.NUM_CORES(4), .CORE_W(2), .CNT_W(16)) dut (
    .CLK(CLK), .RSTB(RSTB), .bus(bus), .conflict_cnt(conflict_cnt)
  );

  always #5 CLK = ~CLK;
  assign bus.core_req = t_req;
  assign bus.core_we = t_we;
  assign bus.core_addr = {t_addr[3], t_addr[2], t_addr[1], t_addr[0]};
  assign bus.core_wdata = {t_wd[3], t_wd[2], t_wd[1], t_wd[0]};
  assign bus.mem_rdata_a = mem_arr[bus.mem_addr_a[8:2]];
  assign bus.mem_rdata_b = mem_arr[bus.mem_addr_b[8:2]];
  always @(posedge CLK) begin
    if (bus.mem_we_a) mem_arr[bus.mem_addr_a[8:2]] <= bus.mem_wdata_a;
    if (bus.mem_we_b) mem_arr[bus.mem_addr_b[8:2]] <= bus.mem_wdata_b;
  end

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from the arbitration rules, compare ports mid-cycle and registers after the edge.
  task automatic cycle(string tag);
    int g[$];
    bit hz = 0;
    logic [127:0] pa = '0, pb = '0, nr;
    logic [3:0] nv = '0, ne = '0;
    @(negedge CLK);
    nr = exp_rdata;
    if (RSTB) begin
      for (int k = 0; k < 4; k++) begin
        int ci = (m_rr + k) % 4;
        if (t_req[ci] && !m_busy[ci]) begin
          if (t_addr[ci] >= 32'h200) begin
            ne[ci] = 1'b1;
            nv[ci] = 1'b1;
            nr[32*ci +: 32] = '0;
          end else if (g.size() == 0) g.push_back(ci);
          else if (g.size() == 1) begin
            if (t_addr[ci][31:2] == t_addr[g[0]][31:2] && (t_we[ci] || t_we[g[0]])) hz = 1;
            else g.push_back(ci);
          end
        end
      end
      if (g.size() > 0) pa = {63'b0, t_we[g[0]], t_addr[g[0]], t_wd[g[0]]};
      if (g.size() > 1) pb = {63'b0, t_we[g[1]], t_addr[g[1]], t_wd[g[1]]};
      foreach (g[j]) begin
        nv[g[j]] = 1'b1;
        nr[32*g[j] +: 32] = ref_mem[t_addr[g[j]][8:2]];
      end
      foreach (g[j]) if (t_we[g[j]]) ref_mem[t_addr[g[j]][8:2]] = t_wd[g[j]];
      if (g.size() > 0) m_rr = (g[$] + 1) % 4;
      if (hz && m_cnt < 65535) m_cnt++;
    end else begin
      nr = '0;
      m_rr = 0;
      m_cnt = 0;
    end
    obs_pa = {63'b0, bus.mem_we_a, bus.mem_addr_a, bus.mem_wdata_a};
    obs_pb = {63'b0, bus.mem_we_b, bus.mem_addr_b, bus.mem_wdata_b};
    check({tag, "/portA"}, obs_pa, pa);
    check({tag, "/portB"}, obs_pb, pb);
    m_busy = nv;
    exp_valid = nv;
    exp_rdata = nr;
    @(posedge CLK);
    #1;
    check({tag, "/resp_valid"}, 128'(bus.core_resp_valid), 128'(nv));
    check({tag, "/resp_err"}, 128'(bus.core_resp_err), 128'(ne));
    check({tag, "/rdata"}, bus.core_rdata, nr);
    check({tag, "/conflict_cnt"}, 128'(conflict_cnt), 128'(m_cnt));
  endtask

  task automatic set_core(int i, logic r, logic w, logic [31:0] a, logic [31:0] d);
    t_req[i] = r;
    t_we[i] = w;
    t_addr[i] = a;
    t_wd[i] = d;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) set_core(i, 1'b1, 1'b1, 32'h0, 32'hA5A5_0000 + i);
    RSTB = 1'b0;
    cycle("reset0");
    cycle("reset1");
    check("reset/valid", 128'(bus.core_resp_valid), 128'h0);
    check("reset/cnt", 128'(conflict_cnt), 128'h0);
    check("reset/mem0", 128'(mem_arr[0]), 128'h0);
    t_req = '0;
    RSTB = 1'b1;
    cycle("idle");
    check("idle/valid", 128'(bus.core_resp_valid), 128'h0);
    set_core(1, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    cycle("store");
    check("store/portA", obs_pa, {63'b0, 1'b1, 32'h10, 32'hDEAD_BEEF});
    check("store/valid", 128'(bus.core_resp_valid), 128'b0010);
    t_req = '0;
    cycle("store_gap");
    set_core(1, 1'b1, 1'b0, 32'h10, 32'h0);
    cycle("load");
    check("load/valid", 128'(bus.core_resp_valid), 128'b0010);
    check("load/rdata", 128'(bus.core_rdata[63:32]), 128'hDEAD_BEEF);
    t_req = '0;
    RSTB = 1'b0;
    cycle("rr_reset");
    RSTB = 1'b1;
    for (int i = 0; i < 4; i++) set_core(i, 1'b1, 1'b0, 32'h40 + 4 * i, 32'h0);
    cycle("rr1");
    check("rr1/valid", 128'(bus.core_resp_valid), 128'b0011);
    cycle("rr2");
    check("rr2/valid", 128'(bus.core_resp_valid), 128'b1100);
    cycle("rr3");
    check("rr3/valid", 128'(bus.core_resp_valid), 128'b0011);
    t_req = '0;
    RSTB = 1'b0;
    cycle("hz_reset");
    RSTB = 1'b1;
    set_core(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
    set_core(1, 1'b1, 1'b0, 32'h20, 32'h0);
    cycle("hz1");
    check("hz1/valid", 128'(bus.core_resp_valid), 128'b0001);
    check("hz1/cnt", 128'(conflict_cnt), 128'd1);
    t_req[0] = 1'b0;
    cycle("hz2");
    check("hz2/valid", 128'(bus.core_resp_valid), 128'b0010);
    check("hz2/rdata", 128'(bus.core_rdata[63:32]), 128'h1234_5678);
    t_req = '0;
    cycle("hz_gap");
    set_core(0, 1'b1, 1'b0, 32'h20, 32'h0);
    set_core(1, 1'b1, 1'b0, 32'h20, 32'h0);
    cycle("rd2");
    check("rd2/valid", 128'(bus.core_resp_valid), 128'b0011);
    check("rd2/cnt", 128'(conflict_cnt), 128'd1);
    t_req = '0;
    cycle("oor_gap");
    set_core(2, 1'b1, 1'b0, 32'h400, 32'h0);
    cycle("oor");
    check("oor/portA", obs_pa, 128'h0);
    check("oor/err", 128'(bus.core_resp_err), 128'b0100);
    check("oor/rdata", 128'(bus.core_rdata[95:64]), 128'h0);
    t_req = '0;
    cycle("mid_gap");
    set_core(3, 1'b1, 1'b0, 32'h10, 32'h0);
    cycle("mid_grant");
    RSTB = 1'b0;
    cycle("mid_reset");
    check("mid/valid", 128'(bus.core_resp_valid), 128'h0);
    RSTB = 1'b1;
    cycle("mid_regrant");
    check("mid/regrant", 128'(bus.core_resp_valid), 128'b1000);
    check("mid/rdata", 128'(bus.core_rdata[127:96]), 128'hDEAD_BEEF);
    t_req = '0;
    cycle("rand_gap");
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 4; i++)
        if (!t_req[i] && $urandom_range(0, 1) == 1)
          set_core(i, 1'b1, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0 ? 32'h400 : 32'h0) + 32'($urandom_range(0, 15)),
                   $urandom);
      RSTB = $urandom_range(0, 39) != 0;
      cycle("rand");
      for (int i = 0; i < 4; i++) if (exp_valid[i]) t_req[i] = 1'b0;
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the dual-port data memory (ports A and B, 128 x 32-bit words, word-addressed by addr[31:2]) among NUM_CORES pipeline cores.
- Each cycle it picks up to two pending core requests in round-robin order and drives one onto each memory port.
- Same-word write hazards between the two ports are blocked, and out-of-range addresses are rejected without touching memory.
- Read data is registered and returned to each core one cycle after its grant.

Parameters:
NUM_CORES, 4, number of requesting cores (2..8)
CORE_W, 2, width of core index, equals clog2(NUM_CORES)
CNT_W, 16, width of the saturating conflict counter

Ports:
CLK  input  1  clock, all state updates on rising edge
RSTB  input  1  synchronous active-low reset
core_req  input  NUM_CORES  per-core request, held high until that core's resp_valid
core_we  input  NUM_CORES  per-core write enable (1 = store, 0 = load)
core_addr  input  NUM_CORES*32  per-core byte address, core i in bits [32i+31:32i]
core_wdata  input  NUM_CORES*32  per-core store data, same packing
core_resp_valid  output  NUM_CORES  one-cycle response pulse per core
core_resp_err  output  NUM_CORES  qualifies resp_valid: address out of range
core_rdata  output  NUM_CORES*32  registered load data, valid with resp_valid
mem_we_a  output  1  port A write enable
mem_addr_a  output  32  port A byte address
mem_wdata_a  output  32  port A write data
mem_rdata_a  input  32  port A combinational read data
mem_we_b  output  1  port B write enable
mem_addr_b  output  32  port B byte address
mem_wdata_b  output  32  port B write data
mem_rdata_b  input  32  port B combinational read data
conflict_cnt  output  CNT_W  count of cycles in which a candidate was skipped for a hazard

Behaviour:
- Reset: RSTB is synchronous and active-low; clock is CLK. While RSTB=0 at a rising edge:
  - core_resp_valid, core_resp_err, core_rdata, conflict_cnt, rr_ptr and all busy bits clear to 0.
  - Memory port outputs are combinationally forced to 0 (we, addr, wdata) whenever RSTB=0.
  - Requests present during reset are ignored. A reset mid-operation drops in-flight responses.
- Eligibility: core i is eligible when core_req[i]=1 and busy[i]=0.
  - busy[i] is set the cycle after grant, equal to core_resp_valid[i].
  - A core is therefore granted at most once per two cycles.
- Range check: an address is in range iff addr[31:9]==0. Out-of-range eligible requests:
  - use no port and are always accepted in their cycle;
  - next cycle: resp_valid=1, resp_err=1, rdata=0, no memory write.
- Port selection (combinational):
  - Scan in-range eligible cores from rr_ptr upward, modulo NUM_CORES.
  - First found gets port A.
  - Next found gets port B unless it hazards with A: same addr[31:2] and (we_A or we_candidate).
  - A hazarding candidate is skipped and the scan continues; two reads of the same word are allowed on both ports.
  - Unused port: we=0, addr=0, wdata=0.
- Port drive: addr/we/wdata of the granted core pass straight to the port in the grant cycle. The memory write occurs at that rising edge.
- Response: at the grant edge, core_rdata[i] <= the port's mem_rdata (the pre-write value for stores). Next cycle: resp_valid[i]=1, resp_err[i]=0. Stores return resp_valid with don't-care rdata, driven as the read value.
- core_rdata holds its value until the next response for that core.
- rr_ptr: after any cycle with at least one port grant, rr_ptr <= (index of last port-granted core + 1) mod NUM_CORES. Otherwise it is unchanged. Error-only cycles do not move rr_ptr.
- conflict_cnt increments by 1 in each cycle where at least one candidate was skipped for a hazard. It saturates at all-ones.
- Fairness: any continuously requesting core is granted within NUM_CORES cycles of becoming eligible.
- Latency: request seen in cycle N with a free port -> resp_valid in cycle N+1.

Test Plan:
- Reset/idle: RSTB=0 for 2 cycles with core_req=4'b1111 -> all outputs 0, no mem writes. Then RSTB=1 with req=0 -> ports idle, resp_valid=0.
- Single store then load: core 1 writes 0xDEADBEEF to 0x10; after resp_valid it reads 0x10 -> mem_we_a=1 addr 0x10 in cycle 1; resp_valid[1] in cycle 2; load returns rdata 0xDEADBEEF.
- Round-robin: all 4 cores read distinct addresses every cycle, rr_ptr=0 -> grants {0,1}, then {2,3}, then {0,1}. No core waits more than 2 cycles.
- Hazard: core 0 writes 0x20 and core 1 reads 0x20 simultaneously, rr_ptr=0 -> core 0 on port A, core 1 blocked and granted next cycle with the new value; conflict_cnt=1. Two reads of 0x20 -> both ports granted, conflict_cnt unchanged.
- Out of range: core 2 reads 0x400 -> no port activity for it; next cycle resp_valid[2]=1, resp_err[2]=1, rdata=0.
- Reset mid-op: assert RSTB=0 in the cycle after a grant -> resp_valid stays 0 and busy clears. After release, the same request is re-granted.
